// File: rtl/noc_xfer_engine.sv
// noc_xfer_engine: moves a burst of words from one port FIFO to another, one word per RD/CAP/WR pass.
// Optional stall watchdog is compiled in when NOC_XFER_TIMEOUT_EN is defined.
module noc_xfer_engine #(
  parameter int NPORTS  = 4,
  parameter int DW      = 8,
  parameter int IDXW    = 2,
  parameter int LENW    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [IDXW-1:0]      i_req_src,
  input  logic [IDXW-1:0]      i_req_dest,
  input  logic [LENW-1:0]      i_req_len,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_busy,
  input  logic [NPORTS-1:0]    i_fifo_empty,
  input  logic [NPORTS-1:0]    i_fifo_full,
  output logic [NPORTS-1:0]    o_fifo_rd_en,
  output logic [NPORTS-1:0]    o_fifo_wr_en,
  input  logic [NPORTS*DW-1:0] i_fifo_rd_data,
  output logic [DW-1:0]        o_fifo_wr_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_RD     = 3'd2;
  localparam logic [2:0] S_CAP    = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // One extra bit so an index equal to NPORTS is representable in the legality check.
  localparam logic [IDXW:0] LP_NPORTS = (IDXW+1)'(NPORTS);

  logic [2:0]        r_state;
  logic [IDXW-1:0]   r_src;
  logic [IDXW-1:0]   r_dest;
  logic [LENW-1:0]   r_rem;
  logic [DW-1:0]     r_hold;
  logic              r_done;
  logic              r_err;
  logic              r_busy;
  logic              r_ready;

  logic [NPORTS-1:0] w_src_sel;
  logic [NPORTS-1:0] w_dst_sel;
  logic              w_illegal;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_timeout;

  // Port selects, request legality and the enable-fire conditions for the current state.
  always_comb begin
    w_src_sel = NPORTS'(1) << r_src;
    w_dst_sel = NPORTS'(1) << r_dest;
    w_illegal = ({1'b0, r_src} >= LP_NPORTS) || ({1'b0, r_dest} >= LP_NPORTS) ||
                (r_src == r_dest);
    w_rd_fire = (r_state == S_RD) && ((w_src_sel & ~i_fifo_empty) != {NPORTS{1'b0}});
    w_wr_fire = (r_state == S_WR) && ((w_dst_sel & ~i_fifo_full) != {NPORTS{1'b0}});
  end

`ifdef NOC_XFER_TIMEOUT_EN
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [SW-1:0] r_stall;
  logic          w_waiting;

  // A wait cycle with the counter at TIMEOUT-1 is the TIMEOUT-th stalled cycle.
  always_comb begin
    w_waiting = ((r_state == S_RD) && !w_rd_fire) || ((r_state == S_WR) && !w_wr_fire);
    w_timeout = w_waiting && (r_stall == SW'(TIMEOUT - 1));
  end

  // Stall counter: counts consecutive wait cycles, cleared by any fire or other state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall <= {SW{1'b0}};
    end else if (w_waiting) begin
      r_stall <= r_stall + SW'(1);
    end else begin
      r_stall <= {SW{1'b0}};
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Enables are decoded from registered state so the flag seen in RD/WR gates them the same cycle.
  always_comb begin
    o_fifo_rd_en = w_rd_fire ? w_src_sel : {NPORTS{1'b0}};
    o_fifo_wr_en = w_wr_fire ? w_dst_sel : {NPORTS{1'b0}};
  end

  assign o_req_ready    = r_ready;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_fifo_wr_data = r_hold;

  // Transfer FSM with its status registers; done/err are single-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_src   <= {IDXW{1'b0}};
      r_dest  <= {IDXW{1'b0}};
      r_rem   <= {LENW{1'b0}};
      r_hold  <= {DW{1'b0}};
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_src   <= i_req_src;
            r_dest  <= i_req_dest;
            r_rem   <= i_req_len;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ACCEPT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCEPT: begin
          if (w_illegal) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_rem == {LENW{1'b0}}) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RD;
          end
        end
        S_RD: begin
          if (w_timeout) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_rd_fire) begin
            r_state <= S_CAP;
          end else begin
            r_state <= S_RD;
          end
        end
        S_CAP: begin
          r_hold  <= i_fifo_rd_data[int'(r_src)*DW +: DW];
          r_state <= S_WR;
        end
        S_WR: begin
          if (w_timeout) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_wr_fire) begin
            r_rem <= r_rem - LENW'(1);
            if (r_rem == LENW'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD;
            end
          end else begin
            r_state <= S_WR;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
